sdram_write_arbiter: RTL and testbench
======================================

# sdram_write_arbiter

Shares the single FPGA-to-HPS SDRAM write port (sdram1, Avalon-MM burst write) between two write masters: the framebuffer writer (requester 0) and a second engine such as a clear or blit unit (requester 1). Grants whole bursts only, so beats of different bursts never interleave. Sits between the masters and the `soc_system` sdram1 conduit, in the `clock_50` domain.

## Interface
- `ADDR_WIDTH`, default 29: Avalon word address width.
- `DATA_WIDTH`, default 64: write data width. Byteenable width is `DATA_WIDTH/8`.
- `BURST_WIDTH`, default 8: burstcount width.
- `clock`  in  1: system clock. Single clock domain.
- `reset`  in  1: reset. Synchronous, active-high.
- `m0_address`, `m1_address`  in  ADDR_WIDTH: requester address, valid with the first beat.
- `m0_burstcount`, `m1_burstcount`  in  BURST_WIDTH: burst length, valid with the first beat.
- `m0_writedata`, `m1_writedata`  in  DATA_WIDTH: beat data.
- `m0_byteenable`, `m1_byteenable`  in  DATA_WIDTH/8: beat byte enables.
- `m0_write`, `m1_write`  in  1: beat valid / request.
- `m0_waitrequest`, `m1_waitrequest`  out  1: stall to the requester.
- `s_address`  out  ADDR_WIDTH: to the sdram1 port.
- `s_burstcount`  out  BURST_WIDTH: to the sdram1 port.
- `s_writedata`  out  DATA_WIDTH: to the sdram1 port.
- `s_byteenable`  out  DATA_WIDTH/8: to the sdram1 port.
- `s_write`  out  1: to the sdram1 port.
- `s_waitrequest`  in  1: from the sdram1 port.
- `grant`  out  2: one-hot current owner. 00 when idle.
- `busy`  out  1: high while any burst is granted.

## Operation
- FSM states: IDLE, GRANT0, GRANT1. All are registered. Reset puts the FSM in IDLE, clears `beats_left`, and sets `last_grant=1`.
- Reset output values:
  - `s_write=0`.
  - `grant=00`, `busy=0`.
  - `m0_waitrequest=1`, `m1_waitrequest=1`.
  - `s_address`, `s_burstcount`, `s_writedata` and `s_byteenable` are 0.
- IDLE behaviour:
  - Both waitrequests are 1.
  - `s_write=0` and all other slave outputs are 0.
  - If exactly one `mN_write` is high, that requester is selected.
  - If both are high, the requester that is not `last_grant` is selected (round-robin).
  - On selection, `beats_left` loads the selected requester's burstcount. A burstcount of 0 is treated as 1. `last_grant` updates and the FSM moves to GRANTn.
- GRANTn behaviour:
  - The slave outputs are a combinational pass-through of requester n's signals.
  - `mn_waitrequest = s_waitrequest`. The other requester's waitrequest is held at 1.
  - A beat is accepted when `mn_write` is high and `s_waitrequest` is low. Each accepted beat decrements `beats_left`.
  - When a beat is accepted with `beats_left==1`, the FSM returns to IDLE.
  - The requester may drop write between beats. The grant is held and no timeout applies.
- Requests that arrive during a grant wait. The waiting requester sees waitrequest=1 and must hold its signals.
- Arithmetic: `beats_left` is BURST_WIDTH bits, unsigned. It never underflows because the exit is at 1.

## Timing
- Arbitration latency: a request first seen in IDLE at cycle t gives grant at t+1. The earliest accepted beat is at t+1.
- Burst end: when the last beat is accepted at cycle t, the FSM is in IDLE at t+1, with 1 idle cycle between bursts. The next grant is at t+2.
- Peak utilisation is therefore B/(B+1) for back-to-back bursts of length B.
- Simultaneous new requests in IDLE are resolved by the round-robin rule in a single cycle.
- Reset asserted mid-burst: the FSM is in IDLE on the next edge, `s_write=0`, and the partial burst is abandoned. Recovering the SDRAM side is the system-reset owner's responsibility.
- There are no combinational paths from `mN_write` to `mN_waitrequest`. The only combinational path is `s_waitrequest` to `mN_waitrequest`.

## Configuration
- `SDRAM_ARB_FIXED_PRIORITY_EN`:
  - Defined: requester 0 wins every IDLE arbitration where both request. `last_grant` is still maintained but ignored.
  - Undefined (default): round-robin as described in Operation.
- All other behaviour is identical in both configurations.

## Test plan
- **Single burst, no stalls:** m0 requests burstcount=4 at address 0x100, s_waitrequest=0.
  - `grant=01` one cycle later.
  - Exactly 4 `s_write` beats with address 0x100 and burstcount 4 on the first beat.
  - IDLE the cycle after the 4th beat.
  - m1_waitrequest is 1 throughout.
- **Simultaneous requests, round-robin:** m0 and m1 both request repeatedly with burstcount=2.
  - Grants alternate 01, 10, 01, 10, starting with 01 after reset.
  - Beats from the two requesters never interleave within a burst.
- **Slave stalls:** m1 sends a burst of 3 while s_waitrequest toggles 1,0,1,1,0,0.
  - m1_waitrequest mirrors s_waitrequest.
  - Exactly 3 accepted beats.
  - `beats_left` does not change on stalled cycles.
- **Zero length and gaps:** m0 burstcount=0 is granted for exactly 1 beat. m0 drops write for 5 cycles mid-burst and `grant` stays 01.
- **Reset mid-burst:** assert reset after beat 2 of 8.
  - Next cycle: `s_write=0`, `grant=00`, both waitrequests 1.
  - A fresh m1 request after reset is granted normally.
- **With `SDRAM_ARB_FIXED_PRIORITY_EN`:** both requesters continuously request bursts of 1. Every grant is 01 and m1 is never granted.

Source files
------------

// File: rtl/sdram_write_arbiter.sv
// Two-master burst write arbiter for the shared HPS sdram1 port; grants whole bursts only.
// Optional macro SDRAM_ARB_FIXED_PRIORITY_EN: requester 0 always wins contended arbitration.
module sdram_write_arbiter #(
    parameter int ADDR_WIDTH  = 29,
    parameter int DATA_WIDTH  = 64,
    parameter int BURST_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     m0_address,
    input  logic [BURST_WIDTH-1:0]    m0_burstcount,
    input  logic [DATA_WIDTH-1:0]     m0_writedata,
    input  logic [DATA_WIDTH/8-1:0]   m0_byteenable,
    input  logic                      m0_write,
    output logic                      m0_waitrequest,
    input  logic [ADDR_WIDTH-1:0]     m1_address,
    input  logic [BURST_WIDTH-1:0]    m1_burstcount,
    input  logic [DATA_WIDTH-1:0]     m1_writedata,
    input  logic [DATA_WIDTH/8-1:0]   m1_byteenable,
    input  logic                      m1_write,
    output logic                      m1_waitrequest,
    output logic [ADDR_WIDTH-1:0]     s_address,
    output logic [BURST_WIDTH-1:0]    s_burstcount,
    output logic [DATA_WIDTH-1:0]     s_writedata,
    output logic [DATA_WIDTH/8-1:0]   s_byteenable,
    output logic                      s_write,
    input  logic                      s_waitrequest,
    output logic [1:0]                grant,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t                 r_state;
    logic [BURST_WIDTH-1:0] r_beats_left;
    logic                   r_last_grant;
    logic [1:0]             r_grant;
    logic                   r_busy;

    logic                   w_pick1;
    logic [BURST_WIDTH-1:0] w_sel_bc;
    logic [BURST_WIDTH-1:0] w_sel_len;
    logic                   w_accept;

`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
    assign w_pick1 = m1_write && !m0_write;
`else
    // On contention, hand the port to whichever requester did not own the previous burst.
    assign w_pick1 = m1_write && (!m0_write || !r_last_grant);
`endif

    assign w_sel_bc  = w_pick1 ? m1_burstcount : m0_burstcount;
    assign w_sel_len = (w_sel_bc == '0) ? BURST_WIDTH'(1) : w_sel_bc;
    assign w_accept  = !s_waitrequest &&
                       (((r_state == GRANT0) && m0_write) || ((r_state == GRANT1) && m1_write));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_beats_left <= '0;
            r_last_grant <= 1'b1;
            r_grant      <= 2'b00;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m0_write || m1_write) begin
                        r_state      <= w_pick1 ? GRANT1 : GRANT0;
                        r_beats_left <= w_sel_len;
                        r_last_grant <= w_pick1;
                        r_grant      <= w_pick1 ? 2'b10 : 2'b01;
                        r_busy       <= 1'b1;
                    end
                end
                default: begin
                    // Leaving at a count of one keeps beats_left from ever wrapping.
                    if (w_accept) begin
                        if (r_beats_left == BURST_WIDTH'(1)) begin
                            r_state <= IDLE;
                            r_grant <= 2'b00;
                            r_busy  <= 1'b0;
                        end else begin
                            r_beats_left <= r_beats_left - BURST_WIDTH'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign busy  = r_busy;

    always_comb begin
        s_address      = '0;
        s_burstcount   = '0;
        s_writedata    = '0;
        s_byteenable   = '0;
        s_write        = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (r_state)
            GRANT0: begin
                s_address      = m0_address;
                s_burstcount   = m0_burstcount;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                s_write        = m0_write;
                m0_waitrequest = s_waitrequest;
            end
            GRANT1: begin
                s_address      = m1_address;
                s_burstcount   = m1_burstcount;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                s_write        = m1_write;
                m1_waitrequest = s_waitrequest;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_write_arbiter.sv
// Scoreboard bench for sdram_write_arbiter: burst-level reference model plus beat monitor.
module tb_sdram_write_arbiter;
    localparam int AW  = 29;
    localparam int DW  = 64;
    localparam int BW  = 8;
    localparam int BEW = DW / 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic           reset;
    logic [AW-1:0]  m0_address, m1_address, s_address;
    logic [BW-1:0]  m0_burstcount, m1_burstcount, s_burstcount;
    logic [DW-1:0]  m0_writedata, m1_writedata, s_writedata;
    logic [BEW-1:0] m0_byteenable, m1_byteenable, s_byteenable;
    logic           m0_write, m1_write, s_write;
    logic           m0_waitrequest, m1_waitrequest, s_waitrequest;
    logic [1:0]     grant;
    logic           busy;

    sdram_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) dut (
        .clock(clock), .reset(reset),
        .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_writedata(m0_writedata),
        .m0_byteenable(m0_byteenable), .m0_write(m0_write), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_writedata(m1_writedata),
        .m1_byteenable(m1_byteenable), .m1_write(m1_write), .m1_waitrequest(m1_waitrequest),
        .s_address(s_address), .s_burstcount(s_burstcount), .s_writedata(s_writedata),
        .s_byteenable(s_byteenable), .s_write(s_write), .s_waitrequest(s_waitrequest),
        .grant(grant), .busy(busy)
    );

    typedef struct {
        logic [AW-1:0]  addr;
        logic [BW-1:0]  bc;
        logic [DW-1:0]  data;
        logic [BEW-1:0] be;
    } beat_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] bc;
        int            gap;
    } burst_t;

    beat_t  exp_q[$];
    burst_t req_q[2][$];
    int     stall_q[$];
    int     grant_log[$];

    // master driver state
    logic           act[2];
    burst_t         cur[2];
    int             idx[2], len[2], hole[2], gapc[2], force_hole[2];
    logic [DW-1:0]  dat[2][16];
    logic [BEW-1:0] ben[2][16];
    logic           drv_w[2];
    int             stall_pct, hole_pct;
    logic           rst_req;

    // reference model state
    int own, rem, last;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic drive();
        for (int n = 0; n < 2; n++) begin
            if (!act[n] && req_q[n].size() > 0) begin
                if (gapc[n] < 0) gapc[n] = req_q[n][0].gap;
                if (gapc[n] == 0) begin
                    cur[n]  = req_q[n].pop_front();
                    gapc[n] = -1;
                    act[n]  = 1'b1;
                    idx[n]  = 0;
                    hole[n] = 0;
                    len[n]  = (cur[n].bc == 0) ? 1 : int'(cur[n].bc);
                    for (int i = 0; i < 16; i++) begin
                        dat[n][i] = {$urandom, $urandom};
                        ben[n][i] = BEW'($urandom);
                    end
                end else begin
                    gapc[n]--;
                end
            end
            drv_w[n] = act[n] && (hole[n] == 0);
        end
        m0_write      = drv_w[0];
        m0_address    = act[0] ? cur[0].addr : AW'($urandom);
        m0_burstcount = act[0] ? cur[0].bc : BW'($urandom);
        m0_writedata  = act[0] ? dat[0][idx[0]] : {$urandom, $urandom};
        m0_byteenable = act[0] ? ben[0][idx[0]] : BEW'($urandom);
        m1_write      = drv_w[1];
        m1_address    = act[1] ? cur[1].addr : AW'($urandom);
        m1_burstcount = act[1] ? cur[1].bc : BW'($urandom);
        m1_writedata  = act[1] ? dat[1][idx[1]] : {$urandom, $urandom};
        m1_byteenable = act[1] ? ben[1][idx[1]] : BEW'($urandom);
        if (stall_q.size() > 0) s_waitrequest = (stall_q.pop_front() != 0);
        else                    s_waitrequest = ($urandom_range(99) < stall_pct);
        reset = rst_req;
    endtask

    task automatic step_model();
        logic [1:0]     eg;
        logic           ebusy, ew0, ew1, esw;
        logic [AW-1:0]  ea;
        logic [BW-1:0]  ebc;
        logic [DW-1:0]  ed;
        logic [BEW-1:0] ebe;
        logic [114:0]   expv, actv;
        int             pick, blen;
        beat_t          b;
        eg = 2'b00; ebusy = 1'b0; ew0 = 1'b1; ew1 = 1'b1; esw = 1'b0;
        ea = '0; ebc = '0; ed = '0; ebe = '0;
        if (own == 0) begin
            eg = 2'b01; ebusy = 1'b1; ew0 = s_waitrequest; esw = m0_write;
            ea = m0_address; ebc = m0_burstcount; ed = m0_writedata; ebe = m0_byteenable;
        end else if (own == 1) begin
            eg = 2'b10; ebusy = 1'b1; ew1 = s_waitrequest; esw = m1_write;
            ea = m1_address; ebc = m1_burstcount; ed = m1_writedata; ebe = m1_byteenable;
        end
        expv = {eg, ebusy, ew0, ew1, esw, ea, ebc, ed, ebe};
        actv = {grant, busy, m0_waitrequest, m1_waitrequest, s_write, s_address,
                s_burstcount, s_writedata, s_byteenable};
        n_chk++;
        if (actv === expv) n_pass++;
        else $display("FAIL cycle_outputs cyc=%0d got=%h expected=%h", cyc, actv, expv);

        if (reset) begin
            own = -1; rem = 0; last = 1;
            exp_q.delete();
        end else if (own < 0) begin
            if (m0_write || m1_write) begin
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
                pick = m0_write ? 0 : 1;
`else
                pick = (m0_write && m1_write) ? (1 - last) : (m0_write ? 0 : 1);
`endif
                blen = (cur[pick].bc == 0) ? 1 : int'(cur[pick].bc);
                for (int i = 0; i < blen; i++) begin
                    b.addr = cur[pick].addr;
                    b.bc   = cur[pick].bc;
                    b.data = dat[pick][i];
                    b.be   = ben[pick][i];
                    exp_q.push_back(b);
                end
                own = pick; rem = blen; last = pick;
                grant_log.push_back(pick);
            end
        end else if (((own == 0) ? m0_write : m1_write) && !s_waitrequest) begin
            rem--;
            if (rem == 0) own = -1;
        end
    endtask

    task automatic advance_drivers();
        logic acc;
        for (int n = 0; n < 2; n++) begin
            acc = drv_w[n] && !((n == 0) ? m0_waitrequest : m1_waitrequest);
            if (rst_req) begin
                act[n] = 1'b0; hole[n] = 0;
            end else if (hole[n] > 0) begin
                hole[n]--;
            end else if (acc) begin
                idx[n]++;
                if (idx[n] >= len[n]) act[n] = 1'b0;
                else if (force_hole[n] > 0) begin
                    hole[n] = force_hole[n]; force_hole[n] = 0;
                end else if ($urandom_range(99) < hole_pct) begin
                    hole[n] = $urandom_range(4, 1);
                end
            end
        end
    endtask

    task automatic cycle();
        drive();
        @(negedge clock);
        step_model();
        advance_drivers();
        cyc++;
        @(posedge clock);
        #1;
    endtask

    function automatic bit drained();
        return req_q[0].size() == 0 && req_q[1].size() == 0 && !act[0] && !act[1] &&
               own < 0 && exp_q.size() == 0;
    endfunction

    task automatic run_drain(input string name, input int cap);
        int c = 0;
        while (!drained() && c < cap) begin
            cycle();
            c++;
        end
        n_chk++;
        if (drained()) n_pass++;
        else $display("FAIL %s_drain got=pending(%0d beats) expected=drained within %0d cycles",
                      name, exp_q.size(), cap);
        cycle();
    endtask

    task automatic check_seq(input string name, input int expq[$]);
        bit ok = (grant_log.size() == expq.size());
        for (int i = 0; ok && i < expq.size(); i++) if (grant_log[i] != expq[i]) ok = 0;
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s grants got=%p expected=%p", name, grant_log, expq);
    endtask

    task automatic push_burst(input int n, input int addr, input int bc, input int gap);
        burst_t t;
        t.addr = AW'(addr); t.bc = BW'(bc); t.gap = gap;
        req_q[n].push_back(t);
    endtask

    task automatic do_reset(input int cycles);
        rst_req = 1'b1;
        repeat (cycles) cycle();
        rst_req = 1'b0;
    endtask

    // beat monitor: every accepted slave beat must be the next one the model expects
    initial begin
        beat_t e;
        forever begin
            @(negedge clock);
            if (s_write === 1'b1 && s_waitrequest === 1'b0) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL beat_unexpected got=addr %h data %h expected=no beat",
                             s_address, s_writedata);
                end else begin
                    e = exp_q.pop_front();
                    if (s_address === e.addr && s_burstcount === e.bc &&
                        s_writedata === e.data && s_byteenable === e.be) n_pass++;
                    else $display("FAIL beat_data got=%h/%h/%h/%h expected=%h/%h/%h/%h",
                                  s_address, s_burstcount, s_writedata, s_byteenable,
                                  e.addr, e.bc, e.data, e.be);
                end
            end
        end
    end

    initial begin
        int q[$];
        for (int n = 0; n < 2; n++) begin
            act[n] = 1'b0; idx[n] = 0; len[n] = 1; hole[n] = 0; gapc[n] = -1;
            force_hole[n] = 0; drv_w[n] = 1'b0;
        end
        own = -1; rem = 0; last = 1;
        stall_pct = 0; hole_pct = 0; rst_req = 1'b0;

        do_reset(3);
        repeat (2) cycle();

        push_burst(0, 'h100, 4, 0);
        run_drain("single", 50);
        q = '{0};
        check_seq("single", q);

        do_reset(1);
        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            push_burst(0, 'h200 + i, 2, 0);
            push_burst(1, 'h300 + i, 2, 0);
        end
        run_drain("rr", 200);
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
        q = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        q = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        check_seq("rr", q);

        grant_log.delete();
        stall_q = '{1, 1, 0, 1, 1, 0, 0};
        push_burst(1, 'h400, 3, 0);
        run_drain("stall", 50);

        grant_log.delete();
        push_burst(0, 'h500, 0, 0);
        force_hole[0] = 5;
        push_burst(0, 'h600, 6, 0);
        run_drain("zero_gap", 80);
        q = '{0, 0};
        check_seq("zero_gap", q);

        grant_log.delete();
        push_burst(0, 'h700, 8, 0);
        for (int c = 0; c < 50 && !(act[0] && idx[0] >= 2); c++) cycle();
        n_chk++;
        if (act[0] && idx[0] == 2) n_pass++;
        else $display("FAIL reset_setup got=beat %0d expected=beat 2 of 8", idx[0]);
        stall_q.push_back(1);
        do_reset(1);
        push_burst(1, 'h800, 3, 0);
        run_drain("reset_mid", 50);
        q = '{0, 1};
        check_seq("reset_mid", q);

        do_reset(1);
        grant_log.delete();
        for (int i = 0; i < 6; i++) begin
            push_burst(0, 'h900 + i, 1, 0);
            push_burst(1, 'hA00 + i, 1, 0);
        end
        run_drain("single_beat", 100);
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
        q = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
`else
        q = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif
        check_seq("single_beat", q);

        stall_pct = 30; hole_pct = 20;
        for (int i = 0; i < 60; i++) begin
            push_burst(0, int'($urandom_range(32'h0FFF_FFFF)), $urandom_range(6), $urandom_range(3));
            push_burst(1, int'($urandom_range(32'h0FFF_FFFF)), $urandom_range(6), $urandom_range(3));
        end
        run_drain("random", 20000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
